sram_arbiter: RTL

//   Shares one asynchronous 32-bit SRAM between the core's instruction-fetch port and data port.

---
 rtl/sram_arbiter_pkg.sv | 44 ++++
 rtl/sram_arbiter_if.sv | 22 ++
 rtl/sram_arbiter.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/sram_arbiter_pkg.sv
// Shared types for the SRAM arbiter: FSM state encoding and the SRAM strobe bundle.
package sram_arbiter_pkg;

    localparam int CNT_W = 3;
    localparam logic [3:0] BE_NONE = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_DRD  = 3'd1,
        ST_DWS  = 3'd2,
        ST_DWP  = 3'd3,
        ST_DWH  = 3'd4,
        ST_IRD  = 3'd5,
        ST_DONE = 3'd6
    } state_t;

    typedef struct packed {
        logic ce_n;
        logic oe_n;
        logic we_n;
    } sram_ctl_t;

    // Strobe levels the SRAM should see while the FSM sits in state s.
    function automatic sram_ctl_t ctl_for_state(state_t s);
        sram_ctl_t c;
        c.ce_n = 1'b1;
        c.oe_n = 1'b1;
        c.we_n = 1'b1;
        case (s)
            ST_DRD, ST_IRD: begin
                c.ce_n = 1'b0;
                c.oe_n = 1'b0;
            end
            ST_DWS, ST_DWH: c.ce_n = 1'b0;
            ST_DWP: begin
                c.ce_n = 1'b0;
                c.we_n = 1'b0;
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// Board-side asynchronous SRAM pin bundle; master is the arbiter, slave is the memory.
interface sram_arbiter_if #(
    parameter int ADDR_W = 20
);
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic              ce_n;
    logic              oe_n;
    logic              we_n;
    logic [3:0]        be_n;

    modport master (
        output addr, wdata, ce_n, oe_n, we_n, be_n,
        input  rdata
    );

    modport slave (
        input  addr, wdata, ce_n, oe_n, we_n, be_n,
        output rdata
    );
endinterface

// File: rtl/sram_arbiter.sv
// Serialises data and fetch accesses onto one asynchronous SRAM, data first,
// and stalls the pipeline until every pending access has completed.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int WAIT_CYCLES = 1,
    parameter int ADDR_W      = 20
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  inst_ce_i,
    input  logic [31:0]           inst_addr_i,
    output logic [31:0]           inst_data_o,

    input  logic                  data_ce_i,
    input  logic                  data_we_i,
    input  logic [3:0]            data_sel_i,
    input  logic [31:0]           data_addr_i,
    input  logic [31:0]           data_wdata_i,
    output logic [31:0]           data_rdata_o,

    output logic                  stallreq_o,

    sram_arbiter_if.master        sram
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        be_n_q, be_n_d;
    sram_ctl_t         ctl_q, ctl_d;
    logic [31:0]       inst_data_q, inst_data_d;
    logic [31:0]       data_rdata_q, data_rdata_d;
    logic              last_cyc;
    logic              stall;

    // Byte-offset and above-window address bits are not used by a word-wide SRAM.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{inst_addr_i[1:0], inst_addr_i[31:ADDR_W+2],
                                data_addr_i[1:0], data_addr_i[31:ADDR_W+2]};

    assign last_cyc = (cnt_q == LAST_CNT);

    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (data_ce_i) begin
                    stall   = 1'b1;
                    state_d = data_we_i ? ST_DWS : ST_DRD;
                end else if (inst_ce_i) begin
                    stall   = 1'b1;
                    state_d = ST_IRD;
                end
            end
            ST_DRD: begin
                stall = 1'b1;
                if (last_cyc) begin
                    state_d = inst_ce_i ? ST_IRD : ST_DONE;
                end
            end
            ST_DWS: begin
                stall   = 1'b1;
                state_d = ST_DWP;
            end
            ST_DWP: begin
                stall = 1'b1;
                if (last_cyc) begin
                    state_d = ST_DWH;
                end
            end
            ST_DWH: begin
                stall   = 1'b1;
                state_d = inst_ce_i ? ST_IRD : ST_DONE;
            end
            ST_IRD: begin
                stall = 1'b1;
                if (last_cyc) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // SRAM pins are registered off the next state so they line up with state_q.
    always_comb begin
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        be_n_d       = be_n_q;
        inst_data_d  = inst_data_q;
        data_rdata_d = data_rdata_q;
        ctl_d        = ctl_for_state(state_d);

        if (state_d != state_q) begin
            cnt_d = '0;
            case (state_d)
                ST_DRD: begin
                    addr_d = data_addr_i[ADDR_W+1:2];
                    be_n_d = 4'h0;
                end
                ST_DWS: begin
                    addr_d  = data_addr_i[ADDR_W+1:2];
                    wdata_d = data_wdata_i;
                    be_n_d  = ~data_sel_i;
                end
                ST_IRD: begin
                    addr_d = inst_addr_i[ADDR_W+1:2];
                    be_n_d = 4'h0;
                end
                // Pulse and hold keep the setup-phase address, data and lanes.
                ST_DWP, ST_DWH: ;
                default: be_n_d = BE_NONE;
            endcase
        end else if (state_q inside {ST_DRD, ST_DWP, ST_IRD}) begin
            cnt_d = cnt_q + CNT_ONE;
        end

        if (state_q == ST_DRD && last_cyc) begin
            data_rdata_d = sram.rdata;
        end
        if (state_q == ST_IRD && last_cyc) begin
            inst_data_d = sram.rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            be_n_q       <= BE_NONE;
            ctl_q.ce_n   <= 1'b1;
            ctl_q.oe_n   <= 1'b1;
            ctl_q.we_n   <= 1'b1;
            inst_data_q  <= '0;
            data_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            be_n_q       <= be_n_d;
            ctl_q        <= ctl_d;
            inst_data_q  <= inst_data_d;
            data_rdata_q <= data_rdata_d;
        end
    end

    // Stall is forced low while reset is asserted, even before the reset edge lands.
    assign stallreq_o   = rst & stall;
    assign inst_data_o  = inst_data_q;
    assign data_rdata_o = data_rdata_q;

    assign sram.addr  = addr_q;
    assign sram.wdata = wdata_q;
    assign sram.be_n  = be_n_q;
    assign sram.ce_n  = ctl_q.ce_n;
    assign sram.oe_n  = ctl_q.oe_n;
    assign sram.we_n  = ctl_q.we_n;

endmodule
